// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: request front-end for the single-port SRAM wrapper.
// Turns a valid/ready request stream into RW0_* strobes. Read data returns
// through a credit-guarded response FIFO with valid/ready backpressure.
module sram_req_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst,
    // Request stream
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wmode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    // Response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    // Wrapper port
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata,
    // Status
    output logic              idle
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [CNT_W-1:0]  credit_cnt;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [2:0]        rd_pipe;
    logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

    logic accept;
    logic accept_rd;
    logic push;
    logic pop;
    logic fifo_full;

    // Handshake decode and combinational outputs
    always_comb begin
        req_ready = (credit_cnt < CNT_W'(RSP_DEPTH));
        accept    = req_valid & req_ready;
        accept_rd = accept & ~req_wmode;
        // rd_pipe[2] marks the cycle RW0_rdata carries the oldest in-flight read
        push      = rd_pipe[2];
        rsp_valid = (fifo_cnt != '0);
        pop       = rsp_valid & rsp_ready;
        fifo_full = (fifo_cnt == CNT_W'(RSP_DEPTH));
        // The wrapper registers wdata itself at the accept edge
        RW0_wdata = req_wdata;
        rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : '0;
        idle      = ~RW0_en & (rd_pipe == 3'b000) & (fifo_cnt == '0);
    end

    // Issue stage: one-cycle en pulse per accepted request, addr/wmode held otherwise
    always_ff @(posedge RW0_clk or posedge RW0_rst) begin
        if (RW0_rst) begin
            RW0_en    <= 1'b0;
            RW0_wmode <= 1'b0;
            RW0_addr  <= '0;
        end else begin
            RW0_en <= accept;
            if (accept) begin
                RW0_wmode <= req_wmode;
                RW0_addr  <= req_addr;
            end
        end
    end

    // Read valid pipeline matching the wrapper's two-edge read path
    always_ff @(posedge RW0_clk or posedge RW0_rst) begin
        if (RW0_rst) begin
            rd_pipe <= 3'b000;
        end else begin
            rd_pipe <= {rd_pipe[1:0], accept_rd};
        end
    end

    // Credits: reads accepted but not yet popped, so the FIFO can never overflow
    always_ff @(posedge RW0_clk or posedge RW0_rst) begin
        if (RW0_rst) begin
            credit_cnt <= '0;
        end else begin
            unique case ({accept_rd, pop})
                2'b10:   credit_cnt <= credit_cnt + 1'b1;
                2'b01:   credit_cnt <= credit_cnt - 1'b1;
                default: credit_cnt <= credit_cnt;
            endcase
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge RW0_clk or posedge RW0_rst) begin
        if (RW0_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Response FIFO storage; contents are don't-care until pushed
    always_ff @(posedge RW0_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= RW0_rdata;
        end
    end

    a_no_push_full: assert property (@(posedge RW0_clk) disable iff (RW0_rst)
        !(push && fifo_full));
    a_credit_bound: assert property (@(posedge RW0_clk) disable iff (RW0_rst)
        credit_cnt <= CNT_W'(RSP_DEPTH));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed and random checks of sram_req_ctrl against a
// transaction-level model (memory array + response queue with ready times).
module tb_sram_req_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              RW0_clk = 1'b0;
    logic              RW0_rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_wmode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] RW0_addr;
    logic              RW0_en;
    logic              RW0_wmode;
    logic [DATA_W-1:0] RW0_wdata;
    logic [DATA_W-1:0] RW0_rdata;
    logic              idle;

    sram_req_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RSP_DEPTH(DEPTH)
    ) dut (
        .RW0_clk  (RW0_clk),
        .RW0_rst  (RW0_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wmode(req_wmode),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .RW0_addr (RW0_addr),
        .RW0_en   (RW0_en),
        .RW0_wmode(RW0_wmode),
        .RW0_wdata(RW0_wdata),
        .RW0_rdata(RW0_rdata),
        .idle     (idle)
    );

    always #5 RW0_clk = ~RW0_clk;

    // SRAM wrapper: wdata registered every edge, access at the edge after en, 2-edge read
    logic [DATA_W-1:0] sram [16];
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_q;
    always @(posedge RW0_clk) begin
        wdata_q <= RW0_wdata;
        if (RW0_en && RW0_wmode) sram[RW0_addr] <= wdata_q;
        if (RW0_en && !RW0_wmode) rd_q <= sram[RW0_addr];
        RW0_rdata <= rd_q;
    end

    // Reference model state
    typedef struct {
        logic [DATA_W-1:0] d;
        int                rdy;
    } rsp_t;

    rsp_t              q[$];
    logic [DATA_W-1:0] mem_m [16];
    int                credits;
    int                cyc;
    bit                acc_last;
    logic [ADDR_W-1:0] addr_last;
    bit                wmode_last;
    int                n_cmp;
    int                n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: compare at negedge, advance the model at posedge, drive after #1
    task automatic tick();
        bit exp_valid;
        bit acc_now;
        bit pop_now;
        @(negedge RW0_clk);
        exp_valid = (q.size() > 0) && (q[0].rdy <= cyc);
        check("req_ready", 32'(req_ready), 32'(credits < DEPTH));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) check("rsp_rdata", 32'(rsp_rdata), 32'(q[0].d));
        check("idle", 32'(idle), 32'((credits == 0) && !acc_last));
        check("RW0_en", 32'(RW0_en), 32'(acc_last));
        if (acc_last) begin
            check("RW0_addr", 32'(RW0_addr), 32'(addr_last));
            check("RW0_wmode", 32'(RW0_wmode), 32'(wmode_last));
        end
        check("RW0_wdata", 32'(RW0_wdata), 32'(req_wdata));
        check("credit_cnt", 32'(dut.credit_cnt), 32'(credits));
        acc_now = req_valid && (credits < DEPTH);
        pop_now = exp_valid && rsp_ready;
        @(posedge RW0_clk);
        cyc++;
        if (acc_now) begin
            if (req_wmode) begin
                mem_m[req_addr] = req_wdata;
            end else begin
                q.push_back('{d: mem_m[req_addr], rdy: cyc + 3});
                credits++;
            end
        end
        if (pop_now) begin
            void'(q.pop_front());
            credits--;
        end
        acc_last   = acc_now;
        addr_last  = req_addr;
        wmode_last = req_wmode;
        #1;
    endtask

    task automatic drive(input bit v, input bit w, input int a, input int d);
        req_valid = v;
        req_wmode = w;
        req_addr  = ADDR_W'(a);
        req_wdata = DATA_W'(d);
    endtask

    task automatic drain();
        int n;
        drive(0, 0, 0, 0);
        rsp_ready = 1'b1;
        n = 0;
        while (((credits != 0) || acc_last) && (n < 60)) begin
            tick();
            n++;
        end
        check("drain_bound", 32'(n < 60), 32'd1);
        tick();
    endtask

    initial begin
        int n_acc;
        n_cmp    = 0;
        n_bad    = 0;
        credits  = 0;
        cyc      = 0;
        acc_last = 1'b0;
        rsp_ready = 1'b1;
        drive(0, 0, 0, 0);
        RW0_rst = 1'b1;
        #12;
        check("rst_en", 32'(RW0_en), 32'd0);
        check("rst_wmode", 32'(RW0_wmode), 32'd0);
        check("rst_addr", 32'(RW0_addr), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);
        @(negedge RW0_clk);
        RW0_rst = 1'b0;
        @(posedge RW0_clk);
        #1;

        // Write 3 = BEEF, then read 3
        drive(1, 1, 3, 16'hBEEF);
        tick();
        drive(1, 0, 3, 0);
        tick();
        drive(0, 0, 0, 0);
        repeat (3) tick();
        check("beef_valid", 32'(rsp_valid), 32'd1);
        check("beef_data", 32'(rsp_rdata), 32'hBEEF);
        drain();

        // Fill all addresses back-to-back, then 16 back-to-back reads
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, i, 16'h1000 + i);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, i, 0);
            tick();
        end
        drain();

        // Backpressure: 6 reads offered with rsp_ready low
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, n_acc, 0);
            tick();
            if (acc_last) n_acc++;
        end
        check("bp_accepts", 32'(n_acc), 32'd4);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        drain();

        // Write then read the same address on consecutive edges
        drive(1, 1, 5, 16'hA5A5);
        tick();
        drive(1, 0, 5, 0);
        tick();
        drain();

        // Reset with 2 reads in flight and 2 responses queued
        rsp_ready = 1'b0;
        for (int i = 8; i < 12; i++) begin
            drive(1, 0, i, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        tick();
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        #2;
        RW0_rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_idle", 32'(idle), 32'd1);
        repeat (2) @(posedge RW0_clk);
        #1;
        check("hold_rst_idle", 32'(idle), 32'd1);
        check("hold_rst_valid", 32'(rsp_valid), 32'd0);
        @(negedge RW0_clk);
        RW0_rst = 1'b0;
        q.delete();
        credits  = 0;
        acc_last = 1'b0;
        @(posedge RW0_clk);
        cyc++;
        #1;
        rsp_ready = 1'b1;
        repeat (8) tick();

        // Mixed random traffic with random consumer backpressure
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 16'hFFFF)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();
        check("final_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
